// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU decode/issue controller: ALU opcodes,
// instruction op/funct codes, instruction field positions and FSM states.
package alu_issue_ctrl_pkg;

    // ALU opcodes (5-bit)
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_ADDI = 5'd2;
    localparam logic [4:0] ALU_SUBI = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_J    = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_LW   = 5'd10;
    localparam logic [4:0] ALU_SW   = 5'd11;
    localparam logic [4:0] ALU_ANDI = 5'd12;
    localparam logic [4:0] ALU_SLTI = 5'd13;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Instruction field bit positions
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FN_MSB    = 5;
    localparam int unsigned FN_LSB    = 0;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned JTGT_MSB  = 25;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StMem  = 2'd2,
        StWb   = 2'd3
    } issue_state_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder: op/funct -> ALU opcode, immediate
// extension, destination select and instruction class flags.
module alu_issue_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    output logic [4:0]  o_opc,
    output logic [31:0] o_imm,
    output logic        o_use_imm,
    output logic [4:0]  o_dest,
    output logic        o_is_mem,
    output logic        o_is_store,
    output logic        o_is_jump,
    output logic        o_illegal
);

    // Decode table; anything not listed is flagged illegal
    always_comb begin
        o_opc      = ALU_ADD;
        o_imm      = '0;
        o_use_imm  = 1'b0;
        o_dest     = i_rd;
        o_is_mem   = 1'b0;
        o_is_store = 1'b0;
        o_is_jump  = 1'b0;
        o_illegal  = 1'b0;
        unique case (i_op)
            OP_RTYPE: begin
                unique case (i_funct)
                    FN_ADD:  o_opc = ALU_ADD;
                    FN_SUB:  o_opc = ALU_SUB;
                    FN_AND:  o_opc = ALU_AND;
                    FN_OR:   o_opc = ALU_OR;
                    FN_SLL:  o_opc = ALU_SLL;
                    FN_SRL:  o_opc = ALU_SRL;
                    FN_SLT:  o_opc = ALU_SLT;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                o_opc     = ALU_ADDI;
                o_imm     = sext16(i_imm);
                o_use_imm = 1'b1;
                o_dest    = i_rt;
            end
            OP_SUBI: begin
                o_opc     = ALU_SUBI;
                o_imm     = sext16(i_imm);
                o_use_imm = 1'b1;
                o_dest    = i_rt;
            end
            OP_ANDI: begin
                o_opc     = ALU_ANDI;
                o_imm     = zext16(i_imm);
                o_use_imm = 1'b1;
                o_dest    = i_rt;
            end
            OP_SLTI: begin
                o_opc     = ALU_SLTI;
                o_imm     = sext16(i_imm);
                o_use_imm = 1'b1;
                o_dest    = i_rt;
            end
            OP_LW: begin
                o_opc     = ALU_LW;
                o_imm     = sext16(i_imm);
                o_use_imm = 1'b1;
                o_dest    = i_rt;
                o_is_mem  = 1'b1;
            end
            OP_SW: begin
                o_opc      = ALU_SW;
                o_imm      = sext16(i_imm);
                o_use_imm  = 1'b1;
                o_dest     = i_rt;
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
            end
            OP_J: begin
                o_opc     = ALU_J;
                o_is_jump = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle decode/issue controller for the 5-bit-opcode ALU.
// Sequence per instruction: IDLE -> EXEC -> (MEM) -> WB -> IDLE.
// Optional macro ISSUE_STALL_CNT_EN adds o_stall_cnt, a saturating count of
// MEM cycles spent waiting for mem_ack.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [31:0]       i_instr,
    output logic [REG_AW-1:0] o_rs_addr,
    output logic [REG_AW-1:0] o_rt_addr,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    output logic [DATA_W-1:0] o_alu_inp1,
    output logic [DATA_W-1:0] o_alu_inp2,
    output logic [4:0]        o_alu_opc,
    input  logic [DATA_W-1:0] i_alu_out,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_wb_en,
    output logic [REG_AW-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_jmp_valid,
    output logic [DATA_W-1:0] o_jmp_target,
`ifdef ISSUE_STALL_CNT_EN
    output logic [31:0]       o_stall_cnt,
`endif
    output logic              o_illegal
);

    issue_state_e      r_state;
    issue_state_e      w_state_d;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_result;     // ALU result, replaced by load data on lw
    logic [DATA_W-1:0] r_store_data;

    logic [4:0]  w_opc;
    logic [31:0] w_imm;
    logic        w_use_imm;
    logic [4:0]  w_dest;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_is_jump;
    logic        w_illegal;

    alu_issue_decode u_decode (
        .i_op       (r_instr[OP_MSB:OP_LSB]),
        .i_funct    (r_instr[FN_MSB:FN_LSB]),
        .i_rt       (r_instr[RT_MSB:RT_LSB]),
        .i_rd       (r_instr[RD_MSB:RD_LSB]),
        .i_imm      (r_instr[IMM_MSB:IMM_LSB]),
        .o_opc      (w_opc),
        .o_imm      (w_imm),
        .o_use_imm  (w_use_imm),
        .o_dest     (w_dest),
        .o_is_mem   (w_is_mem),
        .o_is_store (w_is_store),
        .o_is_jump  (w_is_jump),
        .o_illegal  (w_illegal)
    );

    // State register and datapath capture registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_instr      <= '0;
            r_result     <= '0;
            r_store_data <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && i_instr_valid) begin
                r_instr <= i_instr;
            end
            if (r_state == StExec) begin
                r_result     <= i_alu_out;
                r_store_data <= i_rt_data;
            end
            if (r_state == StMem && i_mem_ack && !w_is_store) begin
                r_result <= i_mem_rdata;
            end
        end
    end

    // Next-state and outputs; every output is zero outside the phase that owns it
    always_comb begin
        w_state_d     = r_state;
        o_instr_ready = 1'b0;
        o_rs_addr     = '0;
        o_rt_addr     = '0;
        o_alu_inp1    = '0;
        o_alu_inp2    = '0;
        o_alu_opc     = '0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        o_wb_en       = 1'b0;
        o_wb_addr     = '0;
        o_wb_data     = '0;
        o_jmp_valid   = 1'b0;
        o_jmp_target  = '0;
        o_illegal     = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                o_rs_addr = r_instr[RS_MSB:RS_LSB];
                o_rt_addr = r_instr[RT_MSB:RT_LSB];
                if (!w_illegal) begin
                    o_alu_inp1 = i_rs_data;
                    o_alu_opc  = w_opc;
                    if (w_use_imm) begin
                        o_alu_inp2 = w_imm;
                    end else if (!w_is_jump) begin
                        o_alu_inp2 = i_rt_data;
                    end
                end
                w_state_d = w_is_mem ? StMem : StWb;
            end
            StMem: begin
                o_mem_req   = 1'b1;
                o_mem_we    = w_is_store;
                o_mem_addr  = r_result;
                o_mem_wdata = r_store_data;
                if (i_mem_ack) begin
                    w_state_d = StWb;
                end
            end
            StWb: begin
                // Reset is synchronous, so gate the strobes combinationally
                if (!i_rst) begin
                    if (w_illegal) begin
                        o_illegal = 1'b1;
                    end else if (w_is_jump) begin
                        o_jmp_valid  = 1'b1;
                        o_jmp_target = {6'b0, r_instr[JTGT_MSB:0]};
                    end else if (!w_is_store && w_dest != '0) begin
                        o_wb_en   = 1'b1;
                        o_wb_addr = w_dest;
                        o_wb_data = r_result;
                    end
                end
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of MEM cycles waiting on mem_ack
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == StMem && !i_mem_ack && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a table-driven reference model.
module tb_alu_issue_ctrl;

    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_J   = 3;
    localparam int K_ILL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [31:0] alu_inp1, alu_inp2;
    logic [4:0]  alu_opc;
    logic [31:0] alu_out;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        illegal;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    logic [31:0] regs [32];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];

    alu_issue_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_instr_valid(instr_valid),
        .o_instr_ready(instr_ready),
        .i_instr      (instr),
        .o_rs_addr    (rs_addr),
        .o_rt_addr    (rt_addr),
        .i_rs_data    (rs_data),
        .i_rt_data    (rt_data),
        .o_alu_inp1   (alu_inp1),
        .o_alu_inp2   (alu_inp2),
        .o_alu_opc    (alu_opc),
        .i_alu_out    (alu_out),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ack    (mem_ack),
        .o_wb_en      (wb_en),
        .o_wb_addr    (wb_addr),
        .o_wb_data    (wb_data),
        .o_jmp_valid  (jmp_valid),
        .o_jmp_target (jmp_target),
`ifdef ISSUE_STALL_CNT_EN
        .o_stall_cnt  (stall_cnt),
`endif
        .o_illegal    (illegal)
    );

    // Reference: instruction class, ALU opcode, operand 2 and destination from the op table
    function automatic void model(input logic [31:0] ins, output int kind,
                                  output logic [4:0] opc, output logic [31:0] op2,
                                  output logic [4:0] dest);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sx;
        logic [31:0] zx;
        op   = ins[31:26];
        fn   = ins[5:0];
        sx   = 32'($signed(ins[15:0]));
        zx   = 32'(ins[15:0]);
        kind = K_ALU;
        opc  = 5'd0;
        op2  = regs[ins[20:16]];
        dest = ins[20:16];
        if (op == 6'h00) begin
            dest = ins[15:11];
            case (fn)
                6'h20: opc = 5'd0;
                6'h22: opc = 5'd1;
                6'h24: opc = 5'd4;
                6'h25: opc = 5'd5;
                6'h00: opc = 5'd6;
                6'h02: opc = 5'd7;
                6'h2A: opc = 5'd9;
                default: kind = K_ILL;
            endcase
        end else begin
            case (op)
                6'h08: begin opc = 5'd2;  op2 = sx; end
                6'h09: begin opc = 5'd3;  op2 = sx; end
                6'h0C: begin opc = 5'd12; op2 = zx; end
                6'h0A: begin opc = 5'd13; op2 = sx; end
                6'h23: begin opc = 5'd10; op2 = sx; kind = K_LW; end
                6'h2B: begin opc = 5'd11; op2 = sx; kind = K_SW; end
                6'h02: begin opc = 5'd8;  kind = K_J; end
                default: kind = K_ILL;
            endcase
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns [7];
        logic [5:0]  ops [8];
        logic [31:0] w;
        int          sel;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A};
        ops = '{6'h08, 6'h09, 6'h0C, 6'h0A, 6'h23, 6'h2B, 6'h02, 6'h00};
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel <= 2) begin
            w[31:26] = 6'h00;
            if ($urandom_range(0, 7) != 0) w[5:0] = fns[$urandom_range(0, 6)];
        end else if (sel <= 8) begin
            w[31:26] = ops[$urandom_range(0, 7)];
        end
        return w;
    endfunction

    // One complete instruction from IDLE back to IDLE, checked phase by phase
    task automatic issue(input logic [31:0] ins, input int ack_dly,
                         input logic [31:0] alu_val, input logic [31:0] rdata);
        int          kind;
        int          cyc;
        logic [4:0]  eopc, edest;
        logic [31:0] eop2, est, ewb;
        bit          exp_wb;
        model(ins, kind, eopc, eop2, edest);
        est = regs[ins[20:16]];
        n_total++; if (instr_ready !== 1'b1) $display("FAIL idle_ready got=%b exp=1", instr_ready); else n_pass++;
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        n_total++; if (instr_ready !== 1'b0) $display("FAIL exec_ready got=%b exp=0", instr_ready); else n_pass++;
        if (kind != K_ILL) begin
            n_total++; if (alu_opc !== eopc) $display("FAIL exec_opc ins=%h got=%0d exp=%0d", ins, alu_opc, eopc); else n_pass++;
            n_total++; if (alu_inp1 !== regs[ins[25:21]]) $display("FAIL exec_inp1 ins=%h got=%h exp=%h", ins, alu_inp1, regs[ins[25:21]]); else n_pass++;
        end
        if (kind == K_ALU || kind == K_LW || kind == K_SW) begin
            n_total++; if (alu_inp2 !== eop2) $display("FAIL exec_inp2 ins=%h got=%h exp=%h", ins, alu_inp2, eop2); else n_pass++;
        end
        alu_out = alu_val;
        @(posedge clk); #1;
        alu_out = $urandom;
        if (kind == K_LW || kind == K_SW) begin
            cyc = 0;
            while (cyc <= ack_dly) begin
                n_total++; if (mem_req !== 1'b1) $display("FAIL mem_req cyc=%0d got=%b exp=1", cyc, mem_req); else n_pass++;
                n_total++; if (mem_we !== (kind == K_SW)) $display("FAIL mem_we got=%b exp=%b", mem_we, kind == K_SW); else n_pass++;
                n_total++; if (mem_addr !== alu_val) $display("FAIL mem_addr got=%h exp=%h", mem_addr, alu_val); else n_pass++;
                if (kind == K_SW) begin
                    n_total++; if (mem_wdata !== est) $display("FAIL mem_wdata got=%h exp=%h", mem_wdata, est); else n_pass++;
                end
                if (cyc == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                cyc++;
            end
        end
        exp_wb = (kind == K_ALU || kind == K_LW) && edest != 5'd0;
        ewb    = (kind == K_LW) ? rdata : alu_val;
        n_total++; if (wb_en !== exp_wb) $display("FAIL wb_en ins=%h got=%b exp=%b", ins, wb_en, exp_wb); else n_pass++;
        if (exp_wb) begin
            n_total++; if (wb_addr !== edest) $display("FAIL wb_addr got=%0d exp=%0d", wb_addr, edest); else n_pass++;
            n_total++; if (wb_data !== ewb) $display("FAIL wb_data got=%h exp=%h", wb_data, ewb); else n_pass++;
        end
        n_total++; if (jmp_valid !== (kind == K_J)) $display("FAIL jmp_valid ins=%h got=%b exp=%b", ins, jmp_valid, kind == K_J); else n_pass++;
        if (kind == K_J) begin
            n_total++; if (jmp_target !== {6'b0, ins[25:0]}) $display("FAIL jmp_target got=%h exp=%h", jmp_target, {6'b0, ins[25:0]}); else n_pass++;
        end
        n_total++; if (illegal !== (kind == K_ILL)) $display("FAIL illegal ins=%h got=%b exp=%b", ins, illegal, kind == K_ILL); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL wb_mem_req got=%b exp=0", mem_req); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ((wb_en | jmp_valid | illegal) !== 1'b0) $display("FAIL pulse_width got=%b%b%b exp=000", wb_en, jmp_valid, illegal); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (instr_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", instr_ready); else n_pass++;
        n_total++; if ({mem_req, mem_we, wb_en, jmp_valid, illegal} !== 5'b0) $display("FAIL rst_strobes got=%b exp=0", {mem_req, mem_we, wb_en, jmp_valid, illegal}); else n_pass++;
        n_total++; if ({alu_inp1, alu_inp2, alu_opc} !== '0) $display("FAIL rst_alu got=%h exp=0", {alu_inp1, alu_inp2, alu_opc}); else n_pass++;
        n_total++; if ({mem_addr, mem_wdata, wb_data, jmp_target} !== '0) $display("FAIL rst_data got=%h exp=0", {mem_addr, mem_wdata, wb_data, jmp_target}); else n_pass++;
        n_total++; if ({rs_addr, rt_addr, wb_addr} !== '0) $display("FAIL rst_addr got=%h exp=0", {rs_addr, rt_addr, wb_addr}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_alu_ops();
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 0, 32'd12, 32'h0);
        regs[1] = 32'd10;
        issue({6'h08, 5'd1, 5'd4, 16'hFFFF}, 0, 32'd9, 32'h0);
        issue({6'h0C, 5'd1, 5'd4, 16'hFFFF}, 0, 32'd10, 32'h0);
        issue({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 0, 32'd12, 32'h0);
    endtask

    task automatic test_mem();
        issue({6'h23, 5'd1, 5'd6, 16'h0010}, 3, 32'h0000_0100, 32'hDEAD_BEEF);
        issue({6'h2B, 5'd1, 5'd7, 16'hFFFC}, 0, 32'h0000_0200, 32'h1234_5678);
    endtask

    task automatic test_jump_illegal();
        issue({6'h02, 26'h123}, 0, 32'h5555_5555, 32'h0);
        issue({6'h3F, 26'h2AB_CDEF}, 0, 32'h6666_6666, 32'h0);
        issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F}, 0, 32'h7777_7777, 32'h0);
    endtask

    task automatic test_ack_ignored();
        mem_ack = 1'b1;
        issue({6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h22}, 0, 32'hABCD_0001, 32'h0);
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses      = 0;
        instr_valid = 1'b1;
        instr       = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20};
        for (int i = 0; i < 12; i++) begin
            n_total++; if (instr_ready !== (i % 3 == 0)) $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, instr_ready, i % 3 == 0); else n_pass++;
            if (wb_en === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        n_total++; if (pulses != 4) $display("FAIL b2b_wb_count got=%0d exp=4", pulses); else n_pass++;
    endtask

    task automatic test_reset_mem();
        instr_valid = 1'b1;
        instr       = {6'h23, 5'd1, 5'd6, 16'h0004};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        alu_out     = 32'h40;
        @(posedge clk); #1;
        n_total++; if (mem_req !== 1'b1) $display("FAIL rmem_in_mem got=%b exp=1", mem_req); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rmem_req_drop got=%b exp=0", mem_req); else n_pass++;
        n_total++; if (instr_ready !== 1'b1) $display("FAIL rmem_idle got=%b exp=1", instr_ready); else n_pass++;
        rst     = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++; if ({wb_en, mem_req, instr_ready} !== 3'b001) $display("FAIL rmem_late_ack cyc=%0d got=%b exp=001", i, {wb_en, mem_req, instr_ready}); else n_pass++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_wb();
        instr_valid = 1'b1;
        instr       = {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h25};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        alu_out     = 32'h99;
        @(posedge clk); #1;
        n_total++; if (wb_en !== 1'b1) $display("FAIL rwb_pre got=%b exp=1", wb_en); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (wb_en !== 1'b0) $display("FAIL rwb_suppress got=%b exp=0", wb_en); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++; if (instr_ready !== 1'b1) $display("FAIL rwb_idle got=%b exp=1", instr_ready); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            regs[$urandom_range(0, 31)] = $urandom;
            issue(rand_instr(), $urandom_range(0, 3), $urandom, $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom | 32'h1;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        alu_out     = 32'hFFFF_0000;
        mem_rdata   = 32'h0;
        mem_ack     = 1'b0;
        test_reset();
        test_alu_ops();
        test_mem();
        test_jump_illegal();
        test_ack_ignored();
        test_back_to_back();
        test_reset_mem();
        test_reset_wb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
